// File: rtl/wbck_pkg.sv
// rtl/wbck_pkg.sv - shared constants and types for the write-back port arbiter
package wbck_pkg;

  localparam int WBCK_DW = 32;
  localparam int WBCK_AW = 5;

  localparam int WBCK_SRC_ALU = 0;
  localparam int WBCK_SRC_LSU = 1;
  localparam int WBCK_SRC_MDV = 2;
  localparam int WBCK_SRC_CSR = 3;

  typedef struct packed {
    logic [WBCK_AW-1:0] rdidx;
    logic [WBCK_DW-1:0] wdat;
  } wbck_entry_t;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/wbck_rr_arb_if.sv
// rtl/wbck_rr_arb_if.sv - requester-side and regfile-side signals of the write-back arbiter
interface wbck_rr_arb_if
  import wbck_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DW    = WBCK_DW,
  parameter int AW    = WBCK_AW,
  parameter int SW    = 2
);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*DW-1:0] req_wdat;
  logic [N_REQ*AW-1:0] req_rdidx;
  logic                wbck_valid;
  logic                wbck_ready;
  logic [DW-1:0]       wbck_wdat;
  logic [AW-1:0]       wbck_rdidx;
  logic [SW-1:0]       wbck_src;

  modport slave (
    input  req_valid, req_wdat, req_rdidx, wbck_ready,
    output req_ready, wbck_valid, wbck_wdat, wbck_rdidx, wbck_src
  );

  modport master (
    output req_valid, req_wdat, req_rdidx, wbck_ready,
    input  req_ready, wbck_valid, wbck_wdat, wbck_rdidx, wbck_src
  );

endinterface

// File: rtl/wbck_rr_pick.sv
// rtl/wbck_rr_pick.sv - combinational rotate-priority picker
// Scans i_ptr, i_ptr+1, ... wrapping, and returns the first set request.
module wbck_rr_pick
  import wbck_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int SW    = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [SW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [SW-1:0]    o_idx,
  output logic             o_any
);

  always_comb begin
    int w_pos;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_pos   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= N_REQ) w_pos = w_pos - N_REQ;
      if (!o_any && i_req[w_pos]) begin
        o_any          = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = SW'(w_pos);
      end
    end
  end

endmodule

// File: rtl/wbck_rr_arb.sv
// rtl/wbck_rr_arb.sv - round-robin arbiter for the shared regfile write-back port
// Optional WBCK_ARB_P0_PRIO_EN: requester 0 gets fixed top priority, others stay round-robin.
module wbck_rr_arb
  import wbck_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DW    = WBCK_DW,
  parameter int AW    = WBCK_AW,
  parameter int SW    = 2
) (
  input logic          clk,
  input logic          rst,
  wbck_rr_arb_if.slave bus
);

  buf_state_e       r_state;
  buf_state_e       w_state_nxt;
  logic [SW-1:0]    r_ptr;
  logic [SW-1:0]    w_ptr_nxt;
  logic [DW-1:0]    r_wdat;
  logic [AW-1:0]    r_rdidx;
  logic [SW-1:0]    r_src;

  logic [N_REQ-1:0] w_pick_req;
  logic [N_REQ-1:0] w_pick_grant;
  logic [SW-1:0]    w_pick_idx;
  logic             w_pick_any;
  logic [N_REQ-1:0] w_grant;
  logic [SW-1:0]    w_grant_idx;
  logic             w_any;
  logic             w_ptr_adv;
  logic             w_can_accept;
  logic             w_hs;

`ifdef WBCK_ARB_P0_PRIO_EN
  // Requester 0 bypasses the rotation and never moves the pointer.
  assign w_pick_req  = {bus.req_valid[N_REQ-1:1], 1'b0};
  assign w_any       = bus.req_valid[0] | w_pick_any;
  assign w_grant     = bus.req_valid[0] ? {{(N_REQ-1){1'b0}}, 1'b1} : w_pick_grant;
  assign w_grant_idx = bus.req_valid[0] ? '0 : w_pick_idx;
  assign w_ptr_adv   = ~bus.req_valid[0];
`else
  assign w_pick_req  = bus.req_valid;
  assign w_any       = w_pick_any;
  assign w_grant     = w_pick_grant;
  assign w_grant_idx = w_pick_idx;
  assign w_ptr_adv   = 1'b1;
`endif

  wbck_rr_pick #(
    .N_REQ (N_REQ),
    .SW    (SW)
  ) u_pick (
    .i_req   (w_pick_req),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  // A full buffer can still accept when it drains in the same cycle.
  assign w_can_accept  = (r_state == BUF_EMPTY) | bus.wbck_ready;
  assign w_hs          = w_any & w_can_accept;
  assign bus.req_ready = w_hs ? w_grant : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      BUF_EMPTY: if (w_hs) w_state_nxt = BUF_FULL;
      BUF_FULL:  if (bus.wbck_ready && !w_hs) w_state_nxt = BUF_EMPTY;
      default:   w_state_nxt = BUF_EMPTY;
    endcase
    if (w_hs && w_ptr_adv) begin
      w_ptr_nxt = (w_grant_idx == SW'(N_REQ - 1)) ? '0 : w_grant_idx + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= BUF_EMPTY;
      r_ptr   <= '0;
      r_wdat  <= '0;
      r_rdidx <= '0;
      r_src   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      if (w_hs) begin
        r_wdat  <= bus.req_wdat[int'(w_grant_idx)*DW +: DW];
        r_rdidx <= bus.req_rdidx[int'(w_grant_idx)*AW +: AW];
        r_src   <= w_grant_idx;
      end
    end
  end

  assign bus.wbck_valid = (r_state == BUF_FULL);
  assign bus.wbck_wdat  = r_wdat;
  assign bus.wbck_rdidx = r_rdidx;
  assign bus.wbck_src   = r_src;

endmodule

// File: tb/tb_wbck_rr_arb.sv
// tb/tb_wbck_rr_arb.sv - directed vector table plus randomized model comparison for wbck_rr_arb
module tb_wbck_rr_arb;
  import wbck_pkg::*;

  localparam int N  = 4;
  localparam int DW = WBCK_DW;
  localparam int AW = WBCK_AW;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wbck_rr_arb_if #(.N_REQ(N), .DW(DW), .AW(AW), .SW(SW)) bus ();

  wbck_rr_arb #(.N_REQ(N), .DW(DW), .AW(AW), .SW(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  wbck_entry_t  ent [N];
  logic [N-1:0] cur_rv;
  int           waits [N];

  bit            m_v;
  logic [DW-1:0] m_wdat;
  logic [AW-1:0] m_rdidx;
  int            m_src;
  int            m_ptr;

  typedef struct {
    bit           r;
    logic [N-1:0] rv;
    bit           wr;
    logic [N-1:0] er;
    bit           ev;
    int           es;
    bit           ez;
  } vec_t;
  vec_t tbl [$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(bit r, logic [N-1:0] rv, bit wr, logic [N-1:0] er, bit ev, int es, bit ez);
    vec_t v;
    v.r = r; v.rv = rv; v.wr = wr; v.er = er; v.ev = ev; v.es = es; v.ez = ez;
    tbl.push_back(v);
  endtask

  task automatic drive(bit r, logic [N-1:0] rv, bit wr);
    @(negedge clk);
    rst             = r;
    bus.req_valid   = rv;
    bus.wbck_ready  = wr;
    for (int i = 0; i < N; i++) begin
      bus.req_wdat[i*DW +: DW]  = ent[i].wdat;
      bus.req_rdidx[i*AW +: AW] = ent[i].rdidx;
    end
    #1;
  endtask

  // Expected grant: first valid requester in rotation order starting at the pointer.
  function automatic logic [N-1:0] model_grant(logic [N-1:0] rv, bit wr);
    logic [N-1:0] g;
    g = '0;
    if (m_v && !wr) return g;
`ifdef WBCK_ARB_P0_PRIO_EN
    if (rv[0]) begin
      g[0] = 1'b1;
      return g;
    end
    rv[0] = 1'b0;
`endif
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (rv[i]) begin
        g[i] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic model_edge(bit r, logic [N-1:0] g, bit wr);
    if (r) begin
      m_v = 0; m_wdat = '0; m_rdidx = '0; m_src = 0; m_ptr = 0;
    end else if (g != '0) begin
      int w;
      w = $clog2(g);
      m_v = 1; m_wdat = ent[w].wdat; m_rdidx = ent[w].rdidx; m_src = w;
`ifdef WBCK_ARB_P0_PRIO_EN
      if (w != 0) m_ptr = (w + 1) % N;
`else
      m_ptr = (w + 1) % N;
`endif
    end else if (m_v && wr) begin
      m_v = 0;
    end
  endtask

  initial begin
    ent[0].wdat = 32'h1111_0000; ent[0].rdidx = 5'd0;
    ent[1].wdat = 32'hDEAD_BEEF; ent[1].rdidx = 5'd7;
    ent[2].wdat = 32'h2222_0002; ent[2].rdidx = 5'd18;
    ent[3].wdat = 32'h3333_0003; ent[3].rdidx = 5'd31;
    cur_rv = '0;
    for (int i = 0; i < N; i++) waits[i] = 0;

`ifdef WBCK_ARB_P0_PRIO_EN
    add(0, 4'b1111, 1, 4'b0001, 0, 0, 1);
    add(0, 4'b1111, 1, 4'b0001, 1, 0, 0);
    add(0, 4'b1111, 1, 4'b0001, 1, 0, 0);
    add(0, 4'b1110, 1, 4'b0010, 1, 0, 0);
    add(0, 4'b1110, 1, 4'b0100, 1, 1, 0);
    add(0, 4'b1110, 1, 4'b1000, 1, 2, 0);
    add(0, 4'b1110, 1, 4'b0010, 1, 3, 0);
    add(0, 4'b0000, 1, 4'b0000, 1, 1, 0);
`else
    for (int i = 0; i < 5; i++) add(0, 4'b0000, 1, 4'b0000, 0, 0, 1);
    add(0, 4'b0010, 1, 4'b0010, 0, 0, 1);
    add(0, 4'b0000, 1, 4'b0000, 1, 1, 0);
    add(0, 4'b0000, 1, 4'b0000, 0, 0, 0);
    add(1, 4'b0000, 1, 4'b0000, 0, 0, 0);
    add(0, 4'b1111, 1, 4'b0001, 0, 0, 1);
    add(0, 4'b1111, 1, 4'b0010, 1, 0, 0);
    add(0, 4'b1111, 1, 4'b0100, 1, 1, 0);
    add(0, 4'b1111, 1, 4'b1000, 1, 2, 0);
    add(0, 4'b1111, 1, 4'b0001, 1, 3, 0);
    add(0, 4'b1111, 1, 4'b0010, 1, 0, 0);
    add(0, 4'b0100, 1, 4'b0100, 1, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 4'b1001, 0, 4'b0000, 1, 2, 0);
    add(0, 4'b1001, 1, 4'b1000, 1, 2, 0);
    add(0, 4'b0000, 1, 4'b0000, 1, 3, 0);
    add(0, 4'b0001, 0, 4'b0001, 0, 0, 0);
    add(1, 4'b0000, 0, 4'b0000, 1, 0, 0);
    add(0, 4'b0000, 1, 4'b0000, 0, 0, 1);
    add(0, 4'b0011, 1, 4'b0001, 0, 0, 1);
    add(0, 4'b0000, 1, 4'b0000, 1, 0, 0);
`endif

    drive(1, '0, 1);
    @(posedge clk);
    drive(1, '0, 1);
    @(posedge clk);

    for (int n = 0; n < tbl.size(); n++) begin
      vec_t v;
      v = tbl[n];
      drive(v.r, v.rv, v.wr);
      chk($sformatf("tbl%0d_ready", n), bus.req_ready, v.er);
      chk($sformatf("tbl%0d_valid", n), bus.wbck_valid, v.ev);
      if (v.ev) begin
        chk($sformatf("tbl%0d_src", n), bus.wbck_src, v.es);
        chk($sformatf("tbl%0d_wdat", n), bus.wbck_wdat, ent[v.es].wdat);
        chk($sformatf("tbl%0d_rdidx", n), bus.wbck_rdidx, ent[v.es].rdidx);
      end
      if (v.ez) begin
        chk($sformatf("tbl%0d_zwdat", n), bus.wbck_wdat, 0);
        chk($sformatf("tbl%0d_zrdidx", n), bus.wbck_rdidx, 0);
        chk($sformatf("tbl%0d_zsrc", n), bus.wbck_src, 0);
      end
      @(posedge clk);
    end

    drive(1, '0, 1);
    @(posedge clk);
    model_edge(1, '0, 1);

    for (int c = 0; c < 3000; c++) begin
      bit           r;
      bit           wr;
      logic [N-1:0] eg;
      int           gi;
      r  = ($urandom_range(0, 199) == 0);
      wr = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!cur_rv[i] && $urandom_range(0, 1) == 1) begin
          cur_rv[i]    = 1'b1;
          ent[i].wdat  = $urandom;
          ent[i].rdidx = AW'($urandom);
        end
      end
      drive(r, cur_rv, wr);
      eg = model_grant(cur_rv, wr);
      chk($sformatf("rnd%0d_ready", c), bus.req_ready, eg);
      chk($sformatf("rnd%0d_valid", c), bus.wbck_valid, m_v);
      chk($sformatf("rnd%0d_wdat", c), bus.wbck_wdat, m_wdat);
      chk($sformatf("rnd%0d_rdidx", c), bus.wbck_rdidx, m_rdidx);
      chk($sformatf("rnd%0d_src", c), bus.wbck_src, m_src);
      @(posedge clk);
`ifndef WBCK_ARB_P0_PRIO_EN
      if (r) begin
        for (int i = 0; i < N; i++) waits[i] = 0;
      end else if (eg != '0) begin
        gi = $clog2(eg);
        chk($sformatf("rnd%0d_fair%0d", c, gi), (waits[gi] <= N - 1), 1);
        waits[gi] = 0;
        for (int i = 0; i < N; i++) if (cur_rv[i] && i != gi) waits[i]++;
      end
`endif
      model_edge(r, eg, wr);
      if (eg != '0) begin
        gi = $clog2(eg);
        cur_rv[gi] = 1'($urandom_range(0, 1));
        ent[gi].wdat  = $urandom;
        ent[gi].rdidx = AW'($urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
